// File: rtl/fxp_seq_mult.sv
// fxp_seq_mult: sequential signed fixed-point multiplier (radix-2 shift-add on magnitudes).
// Computes in1 (WI1.WF1) * in2 (WI2.WF2) and formats the product as WIO.WFO with an overflow flag.
// One multiplier bit is consumed per clock; valid/ready handshake on both sides.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid              in_ready   can accept operands (IDLE only)
//   in1        signed multiplicand         in2        signed multiplier
//   out_valid  out/OVF hold a result       out_ready  consumer accepts the result
//   out        signed product, WIO.WFO     OVF        integer part did not fit in WIO bits
//
// Optional build macro FXP_SEQ_MULT_SAT_EN: when defined, an overflowing result saturates to
// the format extreme instead of keeping the sign bit plus the low integer bits.
module fxp_seq_mult #(
    parameter int unsigned WI1 = 4,
    parameter int unsigned WF1 = 4,
    parameter int unsigned WI2 = 4,
    parameter int unsigned WF2 = 4,
    parameter int unsigned WIO = 6,
    parameter int unsigned WFO = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI1+WF1-1:0]   in1,
    input  logic [WI2+WF2-1:0]   in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIO+WFO-1:0]   out,
    output logic                 OVF
);

    localparam int unsigned N1   = WI1 + WF1;
    localparam int unsigned N2   = WI2 + WF2;
    localparam int unsigned WIP  = WI1 + WI2;
    localparam int unsigned WFP  = WF1 + WF2;
    localparam int unsigned WP   = WIP + WFP;
    localparam int unsigned WO   = WIO + WFO;
    localparam int unsigned WL   = WO - 1;
    localparam int unsigned WX   = WP + WO;
    localparam int unsigned CW   = (N2 > 1) ? $clog2(N2) : 1;
    localparam int unsigned SHL  = (WFO >= WFP) ? (WFO - WFP) : 0;
    localparam int unsigned SHR  = (WFP > WFO) ? (WFP - WFO) : 0;
    localparam int unsigned OVSH = WFP + WIO - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [N1-1:0]        r_mcand;
    logic [N2-1:0]        r_mplr;
    logic                 r_sign;
    logic [WP-1:0]        r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WO-1:0]        r_out;
    logic                 r_ovf;
    logic                 r_out_valid;
    logic                 r_in_ready;

    logic                 w_accept;
    logic                 w_step;
    logic                 w_last;
    logic                 w_release;
    logic [N1-1:0]        w_mag1;
    logic [N2-1:0]        w_mag2;
    logic [WP-1:0]        w_addend;
    logic [WP-1:0]        w_acc_next;
    logic [WP-1:0]        w_p;
    logic signed [WX-1:0] w_ext;
    logic signed [WX-1:0] w_hi;
    logic [WL-1:0]        w_low;
    logic                 w_ovf;
    logic [WO-1:0]        w_fmt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_BUSY;
            S_BUSY:  if (r_cnt == CW'(N2 - 1)) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        w_accept  = 1'b0;
        w_step    = 1'b0;
        w_last    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_IDLE:  w_accept  = in_valid;
            S_BUSY: begin
                w_step = 1'b1;
                w_last = (r_cnt == CW'(N2 - 1));
            end
            S_DONE:  w_release = out_ready;
            default: ;
        endcase
    end

    // Operand magnitudes; the most negative value maps to 2^(N-1), which fits unsigned
    assign w_mag1 = in1[N1-1] ? (N1'(0) - in1) : in1;
    assign w_mag2 = in2[N2-1] ? (N2'(0) - in2) : in2;

    // One shift-add iteration; on the last one this is the full magnitude product
    assign w_addend   = r_mplr[0] ? (WP'(r_mcand) << r_cnt) : WP'(0);
    assign w_acc_next = r_acc + w_addend;
    assign w_p        = r_sign ? (WP'(0) - w_acc_next) : w_acc_next;
    assign w_ext      = WX'($signed(w_p));

    // Align the binary point (arithmetic right shift truncates toward -inf)
    assign w_low = WL'((w_ext <<< SHL) >>> SHR);

    // Overflow when the bits above the kept integer range are not a pure sign extension
    assign w_hi  = w_ext >>> OVSH;
    assign w_ovf = !((w_hi == '0) || (&w_hi));

    // Result formatting: sign bit always kept, optional saturation on overflow
    always_comb begin
        w_fmt = {w_p[WP-1], w_low};
`ifdef FXP_SEQ_MULT_SAT_EN
        if (w_ovf) begin
            w_fmt = w_p[WP-1] ? {1'b1, {WL{1'b0}}} : {1'b0, {WL{1'b1}}};
        end
`endif
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand     <= '0;
            r_mplr      <= '0;
            r_sign      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_mcand <= w_mag1;
                r_mplr  <= w_mag2;
                r_sign  <= in1[N1-1] ^ in2[N2-1];
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_acc  <= w_acc_next;
                r_mplr <= r_mplr >> 1;
                r_cnt  <= r_cnt + CW'(1);
            end

            if (w_last) begin
                r_out       <= w_fmt;
                r_ovf       <= w_ovf;
                r_out_valid <= 1'b1;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end

            r_in_ready <= (w_state_next == S_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign OVF       = r_ovf;

endmodule

// File: tb/tb_fxp_seq_mult.sv
// tb_fxp_seq_mult: directed plus random checks of fxp_seq_mult against an arithmetic reference.
module tb_fxp_seq_mult;

    localparam int WI1 = 4;
    localparam int WF1 = 4;
    localparam int WI2 = 4;
    localparam int WF2 = 4;
    localparam int WIO = 6;
    localparam int WFO = 4;
    localparam int N1  = WI1 + WF1;
    localparam int N2  = WI2 + WF2;
    localparam int WFP = WF1 + WF2;
    localparam int WO  = WIO + WFO;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N1-1:0] in1;
    logic [N2-1:0] in2;
    logic          out_valid;
    logic          out_ready;
    logic [WO-1:0] out;
    logic          OVF;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WO-1:0] last_out;
    logic          last_ovf;

    fxp_seq_mult #(
        .WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2), .WIO(WIO), .WFO(WFO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .OVF       (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer product, rescaled with floor, range-checked as a real number
    function automatic logic [WO-1:0] model(input logic [N1-1:0] a, input logic [N2-1:0] b,
                                            output logic ovf);
        longint p, q, ip, lim;
        logic [WO-1:0] r;
        p = longint'($signed(a)) * longint'($signed(b));
        if (WFO >= WFP) q = p <<< (WFO - WFP);
        else            q = p >>> (WFP - WFO);
        ip  = p >>> WFP;
        lim = longint'(1) <<< (WIO - 1);
        ovf = (ip >= lim) || (ip < -lim);
        r = WO'(q);
        if (ovf) begin
`ifdef FXP_SEQ_MULT_SAT_EN
            r = (p < 0) ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
`else
            r[WO-1] = (p < 0);
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "/ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Returns edges from the accepting edge until out_valid is seen (bounded)
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [N1-1:0] a, input logic [N2-1:0] b, input string tag);
        logic [WO-1:0] eo;
        logic          eovf;
        int            lat;
        eo = model(a, b, eovf);
        wait_ready(tag);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "/busy_ready"}, 32'(in_ready), 32'd0);
        wait_result(lat);
        check({tag, "/latency"}, 32'(lat), 32'd8);
        check({tag, "/out"}, 32'(out), 32'(eo));
        check({tag, "/ovf"}, 32'(OVF), 32'(eovf));
        last_out = out;
        last_ovf = OVF;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "/ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WO-1:0] eo;
        logic          eovf;
        logic [WO-1:0] held_out;
        logic          held_ovf;
        int            lat;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in1 = '0;
        in2 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/out", 32'(out), 32'd0);
        check("reset/ovf", 32'(OVF), 32'd0);
        check("reset/in_ready", 32'(in_ready), 32'd1);

        // Directed values with known answers
        run_op(8'h18, 8'h24, "pos");
        check("pos/const", 32'(last_out), 32'h036);
        run_op(8'hE8, 8'h24, "neg");
        check("neg/const", 32'(last_out), 32'h3CA);
        run_op(8'h00, 8'h80, "zero");
        check("zero/const", 32'(last_out), 32'h000);
        run_op(8'h01, 8'h01, "tiny_pos");
        check("tiny_pos/const", 32'(last_out), 32'h000);
        run_op(8'hFF, 8'h01, "tiny_neg");
        check("tiny_neg/const", 32'(last_out), 32'h3FF);
        run_op(8'h78, 8'h78, "ovf_pos");
        check("ovf_pos/flag", 32'(last_ovf), 32'd1);
`ifdef FXP_SEQ_MULT_SAT_EN
        check("ovf_pos/const", 32'(last_out), 32'h1FF);
`else
        check("ovf_pos/const", 32'(last_out), 32'h184);
`endif
        run_op(8'h80, 8'h80, "ovf_minmin");
        check("ovf_minmin/flag", 32'(last_ovf), 32'd1);
`ifdef FXP_SEQ_MULT_SAT_EN
        check("ovf_minmin/const", 32'(last_out), 32'h1FF);
`endif
        run_op(8'h80, 8'h7F, "min_max");
        run_op(8'h7F, 8'hC0, "max_neg");
        run_op(8'h80, 8'h00, "min_zero");

        // Random operand pairs
        for (int i = 0; i < 24; i++) begin
            run_op(N1'($urandom()), N2'($urandom()), $sformatf("rand%0d", i));
        end

        // Backpressure: result must hold while new operands toggle on the input
        wait_ready("bp");
        in1 = 8'h18;
        in2 = 8'h24;
        eo = model(8'h18, 8'h24, eovf);
        in_valid = 1'b1;
        tick();
        wait_result(lat);
        check("bp/latency", 32'(lat), 32'd8);
        held_out = out;
        held_ovf = OVF;
        check("bp/out", 32'(held_out), 32'(eo));
        for (int i = 0; i < 5; i++) begin
            in1 = N1'($urandom());
            in2 = N2'($urandom());
            tick();
            check($sformatf("bp/hold_out%0d", i), 32'(out), 32'(held_out));
            check($sformatf("bp/hold_ovf%0d", i), 32'(OVF), 32'(held_ovf));
            check($sformatf("bp/hold_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp/hold_ready%0d", i), 32'(in_ready), 32'd0);
        end
        in1 = 8'hE8;
        in2 = 8'h24;
        eo = model(8'hE8, 8'h24, eovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp/release_valid", 32'(out_valid), 32'd0);
        check("bp/release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp/next_busy", 32'(in_ready), 32'd0);
        wait_result(lat);
        check("bp/next_latency", 32'(lat), 32'd8);
        check("bp/next_out", 32'(out), 32'(eo));
        check("bp/next_ovf", 32'(OVF), 32'(eovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the third busy cycle discards the operation
        wait_ready("rst_mid");
        in1 = 8'h78;
        in2 = 8'h78;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid/out_valid", 32'(out_valid), 32'd0);
        check("rst_mid/out", 32'(out), 32'd0);
        check("rst_mid/ovf", 32'(OVF), 32'd0);
        check("rst_mid/in_ready", 32'(in_ready), 32'd1);
        run_op(8'h18, 8'h24, "after_rst");
        check("after_rst/const", 32'(last_out), 32'h036);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
